// File: rtl/firebird7_in_gate1_tessent_ijtag_host_driver.sv
// ============================================================================
// firebird7_in_gate1_tessent_ijtag_host_driver
//
// Host-side initiator for a gate1 IJTAG segment network. The block takes one
// scan command, runs optional capture, len shift cycles and optional update on
// the network, and returns the bits shifted out on a response channel.
//
// Timing model:
//   - The FSM advances on posedge ijtag_tck.
//   - The network controls (sel/ce/se/ue/si) are re-registered on negedge
//     ijtag_tck, so they are stable half a cycle before each network posedge.
//   - ijtag_so is sampled on the posedge that ends each shift cycle.
//   - On entry to RESP the block waits one cycle before raising rsp_valid.
//
// Optional feature (compile-time macro IJTAG_DRV_COMPARE_EN):
//   Adds cmd_expect/cmd_mask inputs, latched when the command is accepted, and
//   an rsp_mismatch output that is valid together with rsp_valid.
// ============================================================================
module firebird7_in_gate1_tessent_ijtag_host_driver #(
   parameter int MAX_LEN = 64,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               ijtag_tck,
   input  logic               ijtag_reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   input  logic               cmd_capture,
   input  logic               cmd_update,
`ifdef IJTAG_DRV_COMPARE_EN
   input  logic [MAX_LEN-1:0] cmd_expect,
   input  logic [MAX_LEN-1:0] cmd_mask,
   output logic               rsp_mismatch,
`endif
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               busy,
   output logic               ijtag_sel,
   output logic               ijtag_ce,
   output logic               ijtag_se,
   output logic               ijtag_ue,
   output logic               ijtag_si,
   input  logic               ijtag_so
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_UPDATE  = 3'd3,
      ST_RESP    = 3'd4
   } state_t;

   state_t             state_r;
   logic [LEN_W-1:0]   len_r;
   logic [LEN_W-1:0]   cnt_r;
   logic [MAX_LEN-1:0] data_r;
   logic               upd_r;
   logic [MAX_LEN-1:0] rsp_data_r;
   logic               rsp_valid_r;
   logic               cmd_ready_r;
   logic               busy_r;
   logic               sel_r;
   logic               ce_r;
   logic               se_r;
   logic               ue_r;
   logic               si_r;
   logic [LEN_W-1:0]   len_clamp_s;
   logic               accept_s;

   // State that follows the capture phase (or IDLE when capture is skipped).
   function automatic state_t after_capture(input logic [LEN_W-1:0] len, input logic upd);
      state_t nxt;
      if (len != LEN_ZERO) begin
         nxt = ST_SHIFT;
      end else if (upd) begin
         nxt = ST_UPDATE;
      end else begin
         nxt = ST_RESP;
      end
      return nxt;
   endfunction

   // State that follows the last shift cycle.
   function automatic state_t after_shift(input logic upd);
      return upd ? ST_UPDATE : ST_RESP;
   endfunction

   // Over-long commands are clamped to the largest supported scan length.
   assign len_clamp_s = (cmd_len > MAX_LEN_L) ? MAX_LEN_L : cmd_len;
   assign accept_s    = (state_r == ST_IDLE) && cmd_valid && cmd_ready_r;

   // Command sequencer: walks capture/shift/update/response and samples ijtag_so.
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         state_r     <= ST_IDLE;
         len_r       <= LEN_ZERO;
         cnt_r       <= LEN_ZERO;
         data_r      <= {MAX_LEN{1'b0}};
         upd_r       <= 1'b0;
         rsp_data_r  <= {MAX_LEN{1'b0}};
         rsp_valid_r <= 1'b0;
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  len_r       <= len_clamp_s;
                  data_r      <= cmd_data;
                  upd_r       <= cmd_update;
                  cnt_r       <= LEN_ZERO;
                  rsp_data_r  <= {MAX_LEN{1'b0}};
                  cmd_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  if (cmd_capture) begin
                     state_r <= ST_CAPTURE;
                  end else begin
                     state_r <= after_capture(len_clamp_s, cmd_update);
                  end
               end
            end
            ST_CAPTURE: begin
               state_r <= after_capture(len_r, upd_r);
            end
            ST_SHIFT: begin
               rsp_data_r[cnt_r[IDX_W-1:0]] <= ijtag_so;
               if (cnt_r == (len_r - LEN_ONE)) begin
                  state_r <= after_shift(upd_r);
               end else begin
                  cnt_r <= cnt_r + LEN_ONE;
               end
            end
            ST_UPDATE: begin
               state_r <= ST_RESP;
            end
            ST_RESP: begin
               // One settling cycle, then hold the response until it is taken.
               if (!rsp_valid_r) begin
                  rsp_valid_r <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
                  cmd_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               rsp_valid_r <= 1'b0;
               cmd_ready_r <= 1'b1;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // Network controls retimed to the falling edge so they lead each network posedge.
   always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         sel_r <= 1'b0;
         ce_r  <= 1'b0;
         se_r  <= 1'b0;
         ue_r  <= 1'b0;
         si_r  <= 1'b0;
      end else begin
         sel_r <= (state_r == ST_CAPTURE) || (state_r == ST_SHIFT) || (state_r == ST_UPDATE);
         ce_r  <= (state_r == ST_CAPTURE);
         se_r  <= (state_r == ST_SHIFT);
         ue_r  <= (state_r == ST_UPDATE);
         si_r  <= (state_r == ST_SHIFT) ? data_r[cnt_r[IDX_W-1:0]] : 1'b0;
      end
   end

`ifdef IJTAG_DRV_COMPARE_EN
   logic [MAX_LEN-1:0] expect_r;
   logic [MAX_LEN-1:0] mask_r;
   logic               mismatch_r;

   // Masked compare of the returned vector, evaluated as the response becomes valid.
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         expect_r   <= {MAX_LEN{1'b0}};
         mask_r     <= {MAX_LEN{1'b0}};
         mismatch_r <= 1'b0;
      end else if (accept_s) begin
         expect_r   <= cmd_expect;
         mask_r     <= cmd_mask;
         mismatch_r <= 1'b0;
      end else if ((state_r == ST_RESP) && !rsp_valid_r) begin
         mismatch_r <= |((rsp_data_r ^ expect_r) & mask_r);
      end else begin
         mismatch_r <= mismatch_r;
      end
   end

   assign rsp_mismatch = mismatch_r;
`endif

   assign cmd_ready = cmd_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign busy      = busy_r;
   assign ijtag_sel = sel_r;
   assign ijtag_ce  = ce_r;
   assign ijtag_se  = se_r;
   assign ijtag_ue  = ue_r;
   assign ijtag_si  = si_r;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_ijtag_host_driver.sv
// ============================================================================
// Bench for firebird7_in_gate1_tessent_ijtag_host_driver.
// An 8-bit network model (capture value, shift chain, update register) sits on
// the scan port. Expected responses are derived from the bit stream the chain
// must emit: the first 8 bits come from the chain contents, the rest replay
// the command data delayed by the chain length.
// ============================================================================
module tb_firebird7_in_gate1_tessent_ijtag_host_driver;

   localparam int MAX_LEN = 64;
   localparam int LEN_W   = 7;

   logic               tck = 1'b0;
   logic               rst_n;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [LEN_W-1:0]   cmd_len;
   logic [MAX_LEN-1:0] cmd_data;
   logic               cmd_capture;
   logic               cmd_update;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [MAX_LEN-1:0] rsp_data;
   logic               busy;
   logic               ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, ijtag_so;
`ifdef IJTAG_DRV_COMPARE_EN
   logic [MAX_LEN-1:0] cmd_expect;
   logic [MAX_LEN-1:0] cmd_mask;
   logic               rsp_mismatch;
   logic               exp_mm;
`endif

   always #5 tck = ~tck;

   firebird7_in_gate1_tessent_ijtag_host_driver #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .ijtag_tck   (tck),
      .ijtag_reset (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_len     (cmd_len),
      .cmd_data    (cmd_data),
      .cmd_capture (cmd_capture),
      .cmd_update  (cmd_update),
`ifdef IJTAG_DRV_COMPARE_EN
      .cmd_expect  (cmd_expect),
      .cmd_mask    (cmd_mask),
      .rsp_mismatch(rsp_mismatch),
`endif
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .busy        (busy),
      .ijtag_sel   (ijtag_sel),
      .ijtag_ce    (ijtag_ce),
      .ijtag_se    (ijtag_se),
      .ijtag_ue    (ijtag_ue),
      .ijtag_si    (ijtag_si),
      .ijtag_so    (ijtag_so)
   );

   // 8-bit network model: capture loads cap_val, shift moves toward bit 0, update copies.
   logic [7:0] cap_val = 8'hA5;
   logic [7:0] net_sr  = 8'h00;
   logic [7:0] net_upd = 8'h00;
   assign ijtag_so = net_sr[0];

   always @(posedge tck) begin
      if (ijtag_ce) net_sr <= cap_val;
      else if (ijtag_se) net_sr <= {ijtag_si, net_sr[7:1]};
      if (ijtag_ue) net_upd <= net_sr;
   end

   // Cycle and network-pulse counters sampled at each network posedge.
   int cyc = 0, n_sel = 0, n_ce = 0, n_se = 0, n_ue = 0;
   always @(posedge tck) begin
      cyc <= cyc + 1;
      if (ijtag_sel) n_sel <= n_sel + 1;
      if (ijtag_ce)  n_ce  <= n_ce + 1;
      if (ijtag_se)  n_se  <= n_se + 1;
      if (ijtag_ue)  n_ue  <= n_ue + 1;
   end

   int checks = 0, fails = 0;
   int t_acc, exp_lat, exp_ce, exp_se, exp_ue;
   int b_sel, b_ce, b_se, b_ue;
   bit cur_upd;
   logic [63:0] exp_out;
   logic [7:0]  ref_sr = 8'h00;
   logic [7:0]  exp_net_upd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Builds expectations from the chain contents, drives the command, waits for accept.
   task automatic start_cmd(input int L, input logic [63:0] D, input bit C, input bit U);
      int lc;
      logic [7:0] sr0, nsr;
      bit acc;
      lc  = (L > MAX_LEN) ? MAX_LEN : L;
      sr0 = C ? cap_val : ref_sr;
      exp_out = 64'd0;
      for (int i = 0; i < lc; i++) begin
         if (i < 8) exp_out[i] = sr0[i];
         else       exp_out[i] = D[i-8];
      end
      for (int j = 0; j < 8; j++) begin
         if (j + lc < 8) nsr[j] = sr0[j+lc];
         else            nsr[j] = D[j+lc-8];
      end
      ref_sr      = nsr;
      exp_net_upd = nsr;
      exp_ce  = int'(C);
      exp_se  = lc;
      exp_ue  = int'(U);
      exp_lat = int'(C) + lc + int'(U) + 1;
      cur_upd = U;
`ifdef IJTAG_DRV_COMPARE_EN
      exp_mm = |((exp_out ^ cmd_expect) & cmd_mask);
`endif
      cmd_len     = L[LEN_W-1:0];
      cmd_data    = D;
      cmd_capture = C;
      cmd_update  = U;
      cmd_valid   = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) begin
         acc   = cmd_ready;
         b_sel = n_sel; b_ce = n_ce; b_se = n_se; b_ue = n_ue;
         @(posedge tck); #1;
      end
      t_acc     = cyc;
      cmd_valid = 1'b0;
      chk("cmd_accept", acc, 1);
   endtask

   // Waits (bounded) for the response and checks latency, data and pulse counts.
   task automatic wait_rsp();
      bit seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(posedge tck); #1;
         seen = rsp_valid;
      end
      chk("rsp_seen", seen, 1);
      chk("latency", cyc - t_acc, exp_lat);
      chk("rsp_data", rsp_data, exp_out);
      chk("ce_cycles", n_ce - b_ce, exp_ce);
      chk("se_cycles", n_se - b_se, exp_se);
      chk("ue_cycles", n_ue - b_ue, exp_ue);
      chk("sel_cycles", n_sel - b_sel, exp_ce + exp_se + exp_ue);
      chk("busy_in_rsp", busy, 1);
      if (cur_upd) chk("net_update", net_upd, exp_net_upd);
`ifdef IJTAG_DRV_COMPARE_EN
      chk("rsp_mismatch", rsp_mismatch, exp_mm);
`endif
   endtask

   // Stalls the response for hold cycles, then completes the handshake.
   task automatic finish_rsp(input int hold);
      for (int k = 0; k < hold; k++) begin
         @(posedge tck); #1;
         chk("hold_valid", rsp_valid, 1);
         chk("hold_data", rsp_data, exp_out);
         chk("hold_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge tck); #1;
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 0);
      chk("ready_back", cmd_ready, 1);
   endtask

   initial begin
      int h;
      int seen_rsp;
      logic [63:0] d;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_data = '0;
      cmd_capture = 1'b0; cmd_update = 1'b0; rsp_ready = 1'b0;
`ifdef IJTAG_DRV_COMPARE_EN
      cmd_expect = '0; cmd_mask = '0;
`endif
      // reset state
      repeat (3) @(posedge tck);
      #1;
      chk("reset_net", {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}, 5'b0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_rsp_data", rsp_data, 64'd0);
      rst_n = 1'b1;
      @(posedge tck); #1;
      chk("post_reset_ready", cmd_ready, 1);

      // capture A5, shift 3C, update
      cap_val = 8'hA5;
      start_cmd(8, 64'h3C, 1'b1, 1'b1);
      wait_rsp();
      chk("t2_latency", cyc - t_acc, 11);
      chk("t2_data", rsp_data, 64'hA5);
      chk("t2_net_hold", net_upd, 8'h3C);
      finish_rsp(0);

      // update only, then an empty command
      start_cmd(0, {$urandom, $urandom}, 1'b0, 1'b1);
      wait_rsp();
      finish_rsp(1);
      start_cmd(0, {$urandom, $urandom}, 1'b0, 1'b0);
      wait_rsp();
      finish_rsp(0);

      // stalled response with a second command waiting
      start_cmd(5, {$urandom, $urandom}, 1'b0, 1'b0);
      wait_rsp();
      d = {$urandom, $urandom};
      cmd_valid = 1'b1; cmd_len = 7'd12; cmd_data = d; cmd_capture = 1'b1; cmd_update = 1'b0;
      finish_rsp(5);
      h = cyc;
      start_cmd(12, d, 1'b1, 1'b0);
      chk("b2b_accept_cycle", t_acc, h + 1);
      wait_rsp();
      finish_rsp(2);

`ifdef IJTAG_DRV_COMPARE_EN
      cmd_expect = 64'hA5; cmd_mask = 64'hFF;
      start_cmd(8, {$urandom, $urandom}, 1'b1, 1'b0);
      wait_rsp();
      chk("cmp_match", rsp_mismatch, 0);
      finish_rsp(0);
      cmd_expect = 64'hA4; cmd_mask = 64'h0F;
      start_cmd(8, {$urandom, $urandom}, 1'b1, 1'b0);
      wait_rsp();
      chk("cmp_diff", rsp_mismatch, 1);
      finish_rsp(0);
      cmd_mask = 64'h00;
      start_cmd(8, {$urandom, $urandom}, 1'b1, 1'b0);
      wait_rsp();
      chk("cmp_nomask", rsp_mismatch, 0);
      finish_rsp(0);
`endif

      // reset during shift bit 3 of 8
      start_cmd(8, {$urandom, $urandom}, 1'b1, 1'b1);
      repeat (4) @(posedge tck);
      #5;
      chk("pre_reset_se", ijtag_se, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_net", {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}, 5'b0);
      chk("mid_reset_busy", busy, 0);
      chk("mid_reset_valid", rsp_valid, 0);
      @(posedge tck); #1;
      rst_n = 1'b1;
      seen_rsp = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge tck); #1;
         if (rsp_valid) seen_rsp++;
      end
      chk("no_dropped_rsp", seen_rsp, 0);
      chk("ready_after_reset", cmd_ready, 1);

      // over-long command clamps to MAX_LEN
      start_cmd(MAX_LEN + 5, {$urandom, $urandom}, 1'b1, 1'b0);
      wait_rsp();
      finish_rsp(0);

      // randomized commands
      for (int n = 0; n < 12; n++) begin
`ifdef IJTAG_DRV_COMPARE_EN
         cmd_expect = {$urandom, $urandom};
         cmd_mask   = {$urandom, $urandom};
`endif
         cap_val = 8'($urandom);
         start_cmd(int'($urandom_range(0, 70)), {$urandom, $urandom},
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         wait_rsp();
         finish_rsp(int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
